// File: rtl/rf_ctrl_pkg.sv
// Shared types and default widths for the register-file write scheduler.
package rf_ctrl_pkg;

  typedef enum logic {
    REQ_EX = 1'b0,
    REQ_LD = 1'b1
  } req_id_t;

  localparam int unsigned N_DEFAULT = 6;
  localparam int unsigned M_DEFAULT = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: req[0] is EX, req[1] is LD.
// last_grant only moves on an accepted write.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_t last_grant_q, last_grant_d;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == REQ_LD) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant[1] ? REQ_LD : REQ_EX;
    end
  end

  // Resetting to LD lets EX win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_LD;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Register-file write-port scheduler: arbitrates EX/LD writebacks onto WE3/A3/WD3
// and keeps a per-register busy scoreboard for reservation and hazard detection.
module rf_write_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = M_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic [N-1:0] ex_addr,
  input  logic [M-1:0] ex_data,
  input  logic         ld_valid,
  output logic         ld_ready,
  input  logic [N-1:0] ld_addr,
  input  logic [M-1:0] ld_data,
  input  logic         resv_valid,
  output logic         resv_ready,
  input  logic [N-1:0] resv_addr,
  input  logic [N-1:0] rd_a1,
  input  logic [N-1:0] rd_a2,
  output logic         hazard1,
  output logic         hazard2,
  output logic         WE3,
  output logic [N-1:0] A3,
  output logic [M-1:0] WD3,
  output logic         err_unreserved
);

  localparam int unsigned Regs = 2 ** N;

  logic [Regs-1:0] busy_q, busy_d;
  logic            we3_q;
  logic [N-1:0]    a3_q, a3_d;
  logic [M-1:0]    wd3_q, wd3_d;
  logic            err_q, err_d;
  logic [1:0]      req;
  logic [1:0]      grant;
  logic            accept;

  assign req = {ld_valid, ex_valid};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  // Grants are suppressed during reset so nothing is accepted on the reset edge.
  assign ex_ready   = grant[0] & ~rst;
  assign ld_ready   = grant[1] & ~rst;
  assign accept     = (ex_valid & ex_ready) | (ld_valid & ld_ready);
  assign resv_ready = ~rst & ~busy_q[resv_addr];

  assign hazard1 = busy_q[rd_a1];
  assign hazard2 = busy_q[rd_a2];

  assign WE3            = we3_q;
  assign A3             = a3_q;
  assign WD3            = wd3_q;
  assign err_unreserved = err_q;

  always_comb begin
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (ex_ready) begin
      a3_d  = ex_addr;
      wd3_d = ex_data;
    end else if (ld_ready) begin
      a3_d  = ld_addr;
      wd3_d = ld_data;
    end
  end

  // Clear on commit and set on reservation may hit different entries in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) begin
      busy_d[a3_q] = 1'b0;
    end
    if (resv_valid && resv_ready) begin
      busy_d[resv_addr] = 1'b1;
    end
  end

  assign err_d = err_q | (we3_q & ~busy_q[a3_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      we3_q  <= accept;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler with a behavioural register file on WE3/A3/WD3.
module tb_rf_write_scheduler;

  localparam int unsigned N = 6;
  localparam int unsigned M = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid, ld_valid, resv_valid;
  logic         ex_ready, ld_ready, resv_ready;
  logic [N-1:0] ex_addr, ld_addr, resv_addr, rd_a1, rd_a2;
  logic [M-1:0] ex_data, ld_data;
  logic         hazard1, hazard2;
  logic         WE3;
  logic [N-1:0] A3;
  logic [M-1:0] WD3;
  logic         err_unreserved;

  logic [M-1:0] rf [2**N];

  int n_cmp = 0;
  int n_err = 0;

  rf_write_scheduler #(.N(N), .M(M)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_addr        (ex_addr),
    .ex_data        (ex_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .resv_valid     (resv_valid),
    .resv_ready     (resv_ready),
    .resv_addr      (resv_addr),
    .rd_a1          (rd_a1),
    .rd_a2          (rd_a2),
    .hazard1        (hazard1),
    .hazard2        (hazard2),
    .WE3            (WE3),
    .A3             (A3),
    .WD3            (WD3),
    .err_unreserved (err_unreserved)
  );

  always #5 clk = ~clk;

  // Register file has no reset: it stores whenever WE3 is high.
  always @(posedge clk) begin
    if (WE3) rf[A3] <= WD3;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reserve(input logic [N-1:0] addr);
    resv_valid = 1'b1;
    resv_addr  = addr;
    settle();
    check_eq("resv_ready", 64'(resv_ready), 64'd1);
    tick();
    resv_valid = 1'b0;
  endtask

  logic [N-1:0] c_ex_addr [4] = '{6'd1, 6'd2, 6'd2, 6'd3};
  logic [N-1:0] c_ld_addr [4] = '{6'd5, 6'd5, 6'd6, 6'd6};
  logic         c_ex_win  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [N-1:0] c_a3      [4] = '{6'd1, 6'd5, 6'd2, 6'd6};
  logic [M-1:0] c_wd3     [4] = '{32'h101, 32'h205, 32'h102, 32'h206};
  logic [N-1:0] resv_list [7] = '{6'd3, 6'd8, 6'd1, 6'd5, 6'd2, 6'd6, 6'd9};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b1; ld_valid = 1'b1; resv_valid = 1'b1;
    ex_addr = '0; ld_addr = '0; resv_addr = '0; rd_a1 = '0; rd_a2 = '0;
    ex_data = '0; ld_data = '0;
    settle();
    check_eq("rst_ex_ready", 64'(ex_ready), 64'd0);
    check_eq("rst_ld_ready", 64'(ld_ready), 64'd0);
    check_eq("rst_resv_ready", 64'(resv_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0; resv_valid = 1'b0;
    settle();
    check_eq("reset_we3", 64'(WE3), 64'd0);
    check_eq("reset_a3", 64'(A3), 64'd0);
    check_eq("reset_wd3", 64'(WD3), 64'd0);
    check_eq("reset_err", 64'(err_unreserved), 64'd0);
    check_eq("reset_hazard1", 64'(hazard1), 64'd0);

    foreach (resv_list[i]) reserve(resv_list[i]);

    // Lone EX write of R3.
    ex_valid = 1'b1; ex_addr = 6'd3; ex_data = 32'hDEADBEEF; rd_a1 = 6'd3;
    settle();
    check_eq("t1_ex_ready", 64'(ex_ready), 64'd1);
    check_eq("t1_ld_ready", 64'(ld_ready), 64'd0);
    tick();
    ex_valid = 1'b0;
    check_eq("t1_we3", 64'(WE3), 64'd1);
    check_eq("t1_a3", 64'(A3), 64'd3);
    check_eq("t1_wd3", 64'(WD3), 64'hDEADBEEF);
    check_eq("t1_hazard_during_commit", 64'(hazard1), 64'd1);
    tick();
    check_eq("t1_we3_low", 64'(WE3), 64'd0);
    check_eq("t1_hazard_cleared", 64'(hazard1), 64'd0);
    check_eq("t1_rf3", 64'(rf[3]), 64'hDEADBEEF);

    // Lone LD write leaves last_grant = LD so EX wins the next contention.
    ld_valid = 1'b1; ld_addr = 6'd8; ld_data = 32'h88;
    settle();
    check_eq("ld_alone_ready", 64'(ld_ready), 64'd1);
    check_eq("ld_alone_ex_ready", 64'(ex_ready), 64'd0);
    tick();
    ld_valid = 1'b0;
    tick();

    // Continuous contention alternates with no bubbles.
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1; ex_addr = c_ex_addr[i]; ex_data = 32'h100 + 32'(c_ex_addr[i]);
      ld_valid = 1'b1; ld_addr = c_ld_addr[i]; ld_data = 32'h200 + 32'(c_ld_addr[i]);
      settle();
      check_eq($sformatf("rr_ex_ready_%0d", i), 64'(ex_ready), 64'(c_ex_win[i]));
      check_eq($sformatf("rr_ld_ready_%0d", i), 64'(ld_ready), 64'(!c_ex_win[i]));
      tick();
      check_eq($sformatf("rr_we3_%0d", i), 64'(WE3), 64'd1);
      check_eq($sformatf("rr_a3_%0d", i), 64'(A3), 64'(c_a3[i]));
      check_eq($sformatf("rr_wd3_%0d", i), 64'(WD3), 64'(c_wd3[i]));
    end
    ex_valid = 1'b0; ld_valid = 1'b0;
    tick();
    check_eq("rr_we3_idle", 64'(WE3), 64'd0);
    check_eq("rr_err", 64'(err_unreserved), 64'd0);

    // Reserve R7, hazard, WAW stall, then LD commits R7.
    rd_a1 = 6'd7;
    settle();
    check_eq("r7_hazard_before", 64'(hazard1), 64'd0);
    reserve(6'd7);
    check_eq("r7_hazard_set", 64'(hazard1), 64'd1);
    resv_valid = 1'b1; resv_addr = 6'd7;
    settle();
    check_eq("r7_waw_stall", 64'(resv_ready), 64'd0);
    resv_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 32'h77;
    settle();
    check_eq("r7_ld_ready", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 1'b0;
    check_eq("r7_we3", 64'(WE3), 64'd1);
    check_eq("r7_a3", 64'(A3), 64'd7);
    check_eq("r7_hazard_no_bypass", 64'(hazard1), 64'd1);
    tick();
    check_eq("r7_hazard_cleared", 64'(hazard1), 64'd0);

    // Reserve R2 on the same edge that R9 commits.
    ex_valid = 1'b1; ex_addr = 6'd9; ex_data = 32'h99;
    tick();
    ex_valid = 1'b0;
    check_eq("r9_a3", 64'(A3), 64'd9);
    resv_valid = 1'b1; resv_addr = 6'd2;
    settle();
    check_eq("r2_resv_ready", 64'(resv_ready), 64'd1);
    tick();
    resv_valid = 1'b0;
    rd_a1 = 6'd2; rd_a2 = 6'd9;
    settle();
    check_eq("r2_busy", 64'(hazard1), 64'd1);
    check_eq("r9_cleared", 64'(hazard2), 64'd0);
    check_eq("r9_err", 64'(err_unreserved), 64'd0);

    // Unreserved write of R12 sets the sticky error.
    ex_valid = 1'b1; ex_addr = 6'd12; ex_data = 32'hC;
    tick();
    ex_valid = 1'b0;
    check_eq("r12_we3", 64'(WE3), 64'd1);
    check_eq("r12_err_before_commit", 64'(err_unreserved), 64'd0);
    tick();
    check_eq("r12_err_set", 64'(err_unreserved), 64'd1);
    tick();
    tick();
    check_eq("r12_err_sticky", 64'(err_unreserved), 64'd1);

    // Reset while a write to R2 is on the port and R4 is busy.
    reserve(6'd4);
    ex_valid = 1'b1; ex_addr = 6'd2; ex_data = 32'hABCD;
    tick();
    ex_valid = 1'b0;
    check_eq("mid_we3", 64'(WE3), 64'd1);
    rst = 1'b1;
    ex_valid = 1'b1; ex_addr = 6'd10; ld_valid = 1'b1; ld_addr = 6'd11;
    resv_valid = 1'b1; resv_addr = 6'd5;
    settle();
    check_eq("mid_rst_ex_ready", 64'(ex_ready), 64'd0);
    check_eq("mid_rst_ld_ready", 64'(ld_ready), 64'd0);
    check_eq("mid_rst_resv_ready", 64'(resv_ready), 64'd0);
    tick();
    rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0; resv_valid = 1'b0;
    rd_a1 = 6'd4; rd_a2 = 6'd2;
    settle();
    check_eq("post_rst_rf2", 64'(rf[2]), 64'hABCD);
    check_eq("post_rst_we3", 64'(WE3), 64'd0);
    check_eq("post_rst_a3", 64'(A3), 64'd0);
    check_eq("post_rst_busy4", 64'(hazard1), 64'd0);
    check_eq("post_rst_busy2", 64'(hazard2), 64'd0);
    check_eq("post_rst_err", 64'(err_unreserved), 64'd0);
    ex_valid = 1'b1; ex_addr = 6'd10; ld_valid = 1'b1; ld_addr = 6'd11;
    settle();
    check_eq("post_rst_ex_wins", 64'(ex_ready), 64'd1);
    check_eq("post_rst_ld_loses", 64'(ld_ready), 64'd0);
    tick();
    ex_valid = 1'b0; ld_valid = 1'b0;
    check_eq("post_rst_a3_ex", 64'(A3), 64'd10);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
